// File: rtl/lut_pkg.sv
// Shared constants, state encoding and lane layout for the correction LUT write port.
// Also used by the correction core's LUT receive side.
package lut_pkg;

  localparam int unsigned LUT_ENTRIES     = 327680;
  localparam int unsigned LUT_ENTRY_WIDTH = 20;
  localparam int unsigned LUT_LANE_WIDTH  = 9;

  localparam int unsigned LANE_A_LSB = 0;
  localparam int unsigned LANE_A_MSB = 8;
  localparam int unsigned LANE_B_LSB = 9;
  localparam int unsigned LANE_B_MSB = 17;
  localparam int unsigned LANE_C_LSB = 18;
  localparam int unsigned LANE_C_MSB = 19;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    DONE
  } lut_state_e;

  // Four DQ lanes, dqa in the most significant slot.
  typedef struct packed {
    logic [LUT_LANE_WIDTH-1:0] dqa;
    logic [LUT_LANE_WIDTH-1:0] dqb;
    logic [LUT_LANE_WIDTH-1:0] dqc;
    logic [LUT_LANE_WIDTH-1:0] dqd;
  } lut_lanes_t;

endpackage

// File: rtl/lut_write_streamer_if.sv
// LUT entry stream (valid/ready) in, correction-LUT write bus (nW + DQ lanes) out.
// master is the streamer side, slave is the upstream source / LUT sink side.
interface lut_write_streamer_if;
  import lut_pkg::*;

  logic                       entryValid;
  logic [LUT_ENTRY_WIDTH-1:0] entryData;
  logic                       entryReady;
  logic                       nW;
  logic [LUT_LANE_WIDTH-1:0]  DQa_write;
  logic [LUT_LANE_WIDTH-1:0]  DQb_write;
  logic [LUT_LANE_WIDTH-1:0]  DQc_write;
  logic [LUT_LANE_WIDTH-1:0]  DQd_write;

  modport master (
    input  entryValid, entryData,
    output entryReady, nW, DQa_write, DQb_write, DQc_write, DQd_write
  );

  modport slave (
    output entryValid, entryData,
    input  entryReady, nW, DQa_write, DQb_write, DQc_write, DQd_write
  );

endinterface

// File: rtl/lut_lane_pack.sv
// Combinational packing of one 20-bit LUT entry onto the four DQ lanes.
// With LUT_WRITE_PARITY_EN defined, dqd[0] carries the even parity of the entry.
module lut_lane_pack
  import lut_pkg::*;
(
  input  logic [LUT_ENTRY_WIDTH-1:0] entry,
  output lut_lanes_t                 lanes
);

  always_comb begin
    lanes     = '0;
    lanes.dqa = entry[LANE_A_MSB:LANE_A_LSB];
    lanes.dqb = entry[LANE_B_MSB:LANE_B_LSB];
    lanes.dqc = LUT_LANE_WIDTH'(entry[LANE_C_MSB:LANE_C_LSB]);
`ifdef LUT_WRITE_PARITY_EN
    lanes.dqd[0] = ^entry;
`endif
  end

endmodule

// File: rtl/lut_write_streamer.sv
// Streams ENTRIES LUT entries onto the correction-LUT write port, then settles and reports done.
// Optional: LUT_WRITE_PARITY_EN adds a lane-D parity bit and the parityAcc output.
module lut_write_streamer
  import lut_pkg::*;
#(
  parameter int unsigned ENTRIES       = LUT_ENTRIES,
  parameter int unsigned CNT_WIDTH     = 19,
  parameter int unsigned SETTLE_CYCLES = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  lut_write_streamer_if.master bus,
  output logic [CNT_WIDTH-1:0] entryCount,
  output logic                 busy,
  output logic                 done
`ifdef LUT_WRITE_PARITY_EN
  ,
  output logic                 parityAcc
`endif
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ENTRIES - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_END = SETTLE_W'(SETTLE_CYCLES);

  lut_state_e          state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                nw_q;
  lut_lanes_t          lanes_q;
  lut_lanes_t          packed_lanes;
  logic                accept;
  logic                go;

  // Abort beats start everywhere; start is only looked at in IDLE/DONE.
  assign go             = start && !abort;
  assign bus.entryReady = (state == LOAD) && (entryCount < CNT_MAX);
  assign accept         = bus.entryValid && bus.entryReady;

  lut_lane_pack u_pack (
    .entry (bus.entryData),
    .lanes (packed_lanes)
  );

  // Write strobe defaults high each cycle, so bubbles never repeat a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      nw_q       <= 1'b1;
      lanes_q    <= '0;
      entryCount <= '0;
      settle_cnt <= '0;
    end else begin
      nw_q <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state      <= LOAD;
            entryCount <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            nw_q       <= 1'b0;
            lanes_q    <= packed_lanes;
            entryCount <= entryCount + CNT_WIDTH'(1);
            if (entryCount == CNT_LAST) begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
          end else if (settle_cnt == SETTLE_END) begin
            state <= DONE;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LUT_WRITE_PARITY_EN
  // Running XOR of every entry actually written in this load.
  always_ff @(posedge clk) begin
    if (rst) begin
      parityAcc <= 1'b0;
    end else if (((state == IDLE) || (state == DONE)) && go) begin
      parityAcc <= 1'b0;
    end else if (((state == LOAD) || (state == SETTLE)) && abort) begin
      parityAcc <= 1'b0;
    end else if (accept) begin
      parityAcc <= parityAcc ^ packed_lanes.dqd[0];
    end
  end
`endif

  assign bus.nW        = nw_q;
  assign bus.DQa_write = lanes_q.dqa;
  assign bus.DQb_write = lanes_q.dqb;
  assign bus.DQc_write = lanes_q.dqc;
  assign bus.DQd_write = lanes_q.dqd;

  assign busy = (state == LOAD) || (state == SETTLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_lut_write_streamer.sv
// Directed bench for lut_write_streamer with a 4-entry load and 3 settle cycles.
// Define LUT_WRITE_PARITY_EN to also check lane-D parity and parityAcc.
module tb_lut_write_streamer;
  import lut_pkg::*;

  localparam int unsigned N      = 4;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned CW     = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] entryCount;
  logic          busy;
  logic          done;
`ifdef LUT_WRITE_PARITY_EN
  logic          parityAcc;
`endif

  int checks   = 0;
  int failures = 0;

  lut_write_streamer_if bus ();

  lut_write_streamer #(
    .ENTRIES       (N),
    .CNT_WIDTH     (CW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .entryCount (entryCount),
    .busy       (busy),
    .done       (done)
`ifdef LUT_WRITE_PARITY_EN
    ,
    .parityAcc  (parityAcc)
`endif
  );

  always #5 clk = ~clk;

  logic [35:0] lanes;
  assign lanes = {bus.DQa_write, bus.DQb_write, bus.DQc_write, bus.DQd_write};

  // Test entries and their hand-computed lane values.
  logic [19:0] ent [4] = '{20'hFFFFF, 20'h00001, 20'h40200, 20'h3FFFF};
  logic [8:0]  ea  [4] = '{9'h1FF, 9'h001, 9'h000, 9'h1FF};
  logic [8:0]  eb  [4] = '{9'h1FF, 9'h000, 9'h001, 9'h1FF};
  logic [8:0]  ec  [4] = '{9'h003, 9'h000, 9'h001, 9'h000};
  logic        ep  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [35:0] exp_lanes(input int i);
    logic [8:0] d;
`ifdef LUT_WRITE_PARITY_EN
    d = {8'h00, ep[i]};
`else
    d = 9'h000;
`endif
    return {ea[i], eb[i], ec[i], d};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.entryValid = 1'b0; bus.entryData = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.nW, busy, done, bus.entryReady} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000", {bus.nW, busy, done, bus.entryReady});
    end
    checks++;
    if (lanes !== 36'h0) begin
      failures++; $display("FAIL reset_lanes got=%h exp=0", lanes);
    end
    checks++;
    if (entryCount !== '0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", entryCount);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.nW, busy, done, bus.entryReady} !== 4'b1000) begin
      failures++;
      $display("FAIL idle_ctrl got=%b exp=1000", {bus.nW, busy, done, bus.entryReady});
    end
  endtask

  task automatic test_continuous();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, bus.entryReady, bus.nW, entryCount} !== {4'b1011, 19'd0}) begin
      failures++;
      $display("FAIL load_entry got=%b cnt=%0d exp=1011 cnt=0", {busy, done, bus.entryReady, bus.nW}, entryCount);
    end
    for (int i = 0; i < 4; i++) begin
      bus.entryValid = 1'b1; bus.entryData = ent[i];
      @(negedge clk);
      checks++;
      if (bus.nW !== 1'b0 || lanes !== exp_lanes(i) || entryCount !== CW'(i + 1)) begin
        failures++;
        $display("FAIL cont_write%0d got nW=%b lanes=%h cnt=%0d exp nW=0 lanes=%h cnt=%0d",
                 i, bus.nW, lanes, entryCount, exp_lanes(i), i + 1);
      end
    end
    bus.entryValid = 1'b0; bus.entryData = 20'h55555;
    checks++;
    if ({bus.entryReady, busy} !== 2'b01) begin
      failures++; $display("FAIL settle_ready got=%b exp=01", {bus.entryReady, busy});
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.nW, done} !== {1'b1, (k == 4)}) begin
        failures++;
        $display("FAIL settle_cyc%0d got nW,done=%b exp=%b", k, {bus.nW, done}, {1'b1, (k == 4)});
      end
    end
    checks++;
    if (entryCount !== CW'(4) || lanes !== exp_lanes(3)) begin
      failures++;
      $display("FAIL done_hold got cnt=%0d lanes=%h exp cnt=4 lanes=%h", entryCount, lanes, exp_lanes(3));
    end
`ifdef LUT_WRITE_PARITY_EN
    checks++;
    if (parityAcc !== 1'b1) begin
      failures++; $display("FAIL parity_acc got=%b exp=1", parityAcc);
    end
`endif
  endtask

  task automatic test_bubbles();
    bit vpat [7] = '{1, 0, 0, 1, 1, 0, 1};
    bit npat [7] = '{0, 1, 1, 0, 0, 1, 0};
    int lidx [7] = '{0, 0, 0, 1, 2, 2, 3};
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.entryValid = vpat[c];
      bus.entryData  = vpat[c] ? ent[lidx[c]] : 20'h55555;
      @(negedge clk);
      checks++;
      if (bus.nW !== npat[c] || lanes !== exp_lanes(lidx[c])) begin
        failures++;
        $display("FAIL bubble_cyc%0d got nW=%b lanes=%h exp nW=%b lanes=%h",
                 c, bus.nW, lanes, npat[c], exp_lanes(lidx[c]));
      end
    end
    bus.entryValid = 1'b0;
    checks++;
    if (entryCount !== CW'(4)) begin
      failures++; $display("FAIL bubble_count got=%0d exp=4", entryCount);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL bubble_done_timeout got=%b exp=1", done);
    end
  endtask

  task automatic test_abort();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.entryValid = 1'b1; bus.entryData = ent[i];
      @(negedge clk);
    end
    bus.entryData = ent[2]; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus.entryValid = 1'b0;
    checks++;
    if ({bus.nW, busy, done, bus.entryReady} !== 4'b1000 || entryCount !== CW'(2)) begin
      failures++;
      $display("FAIL abort_next got=%b cnt=%0d exp=1000 cnt=2", {bus.nW, busy, done, bus.entryReady}, entryCount);
    end
    checks++;
    if (lanes !== exp_lanes(1)) begin
      failures++; $display("FAIL abort_lanes got=%h exp=%h", lanes, exp_lanes(1));
    end
`ifdef LUT_WRITE_PARITY_EN
    checks++;
    if (parityAcc !== 1'b0) begin
      failures++; $display("FAIL abort_parity got=%b exp=0", parityAcc);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.nW !== 1'b1 || entryCount !== CW'(2)) begin
      failures++; $display("FAIL abort_hold got nW=%b cnt=%0d exp nW=1 cnt=2", bus.nW, entryCount);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.entryValid = 1'b1; bus.entryData = ent[i];
      @(negedge clk);
      checks++;
      if (bus.nW !== 1'b0 || lanes !== exp_lanes(i)) begin
        failures++;
        $display("FAIL reload_write%0d got nW=%b lanes=%h exp nW=0 lanes=%h", i, bus.nW, lanes, exp_lanes(i));
      end
    end
    bus.entryValid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || entryCount !== CW'(4)) begin
      failures++; $display("FAIL reload_done got done=%b cnt=%0d exp done=1 cnt=4", done, entryCount);
    end
  endtask

  task automatic test_start_busy();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.entryValid = 1'b1; bus.entryData = ent[i];
      start = (i == 1);
      @(negedge clk);
      checks++;
      if (bus.nW !== 1'b0 || entryCount !== CW'(i + 1)) begin
        failures++;
        $display("FAIL busy_start_write%0d got nW=%b cnt=%0d exp nW=0 cnt=%0d", i, bus.nW, entryCount, i + 1);
      end
    end
    bus.entryValid = 1'b0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, done} !== {(k != 4), (k == 4)}) begin
        failures++;
        $display("FAIL settle_start_cyc%0d got busy,done=%b exp=%b", k, {busy, done}, {(k != 4), (k == 4)});
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.entryValid = 1'b1; bus.entryData = ent[0];
    @(negedge clk);
    start = 1'b1; abort = 1'b1; bus.entryData = ent[1];
    @(negedge clk);
    start = 1'b0; abort = 1'b0; bus.entryValid = 1'b0;
    checks++;
    if ({bus.nW, busy, done} !== 3'b100 || entryCount !== CW'(1)) begin
      failures++;
      $display("FAIL start_abort_load got=%b cnt=%0d exp=100 cnt=1", {bus.nW, busy, done}, entryCount);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, done, bus.entryReady} !== 3'b000) begin
      failures++; $display("FAIL start_abort_idle got=%b exp=000", {busy, done, bus.entryReady});
    end
  endtask

  task automatic test_reset_midload();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.entryValid = 1'b1; bus.entryData = ent[i];
      @(negedge clk);
    end
    rst = 1'b1; bus.entryData = ent[2];
    @(negedge clk);
    rst = 1'b0; bus.entryValid = 1'b0;
    checks++;
    if ({bus.nW, busy, done, bus.entryReady} !== 4'b1000 || lanes !== 36'h0 || entryCount !== '0) begin
      failures++;
      $display("FAIL midload_reset got=%b lanes=%h cnt=%0d exp=1000 lanes=0 cnt=0",
               {bus.nW, busy, done, bus.entryReady}, lanes, entryCount);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_bubbles();
    test_abort();
    test_start_busy();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
